// File: rtl/main_control.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute
// and decodes Moore control outputs from the current state.
//
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   op           opcode, sampled in DECODE only
//   irWrite, pcWrite, branch, regWrite, memWrite   write enables
//   iord, regDst, memtoReg, aluSrcA                 1-bit mux selects
//   aluSrcB, aluOp, pcSrc                           2-bit selects
//   state        current state, debug only
module main_control #(
  parameter int OP_WIDTH    = 6,
  parameter int STATE_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [OP_WIDTH-1:0]    op,
  output logic                   irWrite,
  output logic                   pcWrite,
  output logic                   branch,
  output logic                   regWrite,
  output logic                   memWrite,
  output logic                   iord,
  output logic                   regDst,
  output logic                   memtoReg,
  output logic                   aluSrcA,
  output logic [1:0]             aluSrcB,
  output logic [1:0]             aluOp,
  output logic [1:0]             pcSrc,
  output logic [STATE_WIDTH-1:0] state
);

  typedef enum logic [STATE_WIDTH-1:0] {
    FETCH   = STATE_WIDTH'(0),
    DECODE  = STATE_WIDTH'(1),
    MEMADR  = STATE_WIDTH'(2),
    MEMRD   = STATE_WIDTH'(3),
    MEMWB   = STATE_WIDTH'(4),
    MEMWR   = STATE_WIDTH'(5),
    RTYPEEX = STATE_WIDTH'(6),
    RTYPEWB = STATE_WIDTH'(7),
    BEQEX   = STATE_WIDTH'(8),
    ADDIEX  = STATE_WIDTH'(9),
    ADDIWB  = STATE_WIDTH'(10),
    JEX     = STATE_WIDTH'(11)
  } state_t;

  localparam logic [OP_WIDTH-1:0] OP_LW   = OP_WIDTH'(6'b100011);
  localparam logic [OP_WIDTH-1:0] OP_SW   = OP_WIDTH'(6'b101011);
  localparam logic [OP_WIDTH-1:0] OP_RT   = OP_WIDTH'(6'b000000);
  localparam logic [OP_WIDTH-1:0] OP_BEQ  = OP_WIDTH'(6'b000100);
  localparam logic [OP_WIDTH-1:0] OP_ADDI = OP_WIDTH'(6'b001000);
  localparam logic [OP_WIDTH-1:0] OP_J    = OP_WIDTH'(6'b000010);

  state_t st;
  // op is only valid in DECODE, so the load/store choice is kept
  // for the MEMADR branch.
  logic   is_sw;

  always_ff @(posedge clk) begin
    if (reset) begin
      st    <= FETCH;
      is_sw <= 1'b0;
    end else begin
      case (st)
        FETCH:  st <= DECODE;
        DECODE: begin
          is_sw <= (op == OP_SW);
          if (op == OP_LW || op == OP_SW) st <= MEMADR;
          else if (op == OP_RT)           st <= RTYPEEX;
          else if (op == OP_BEQ)          st <= BEQEX;
          else if (op == OP_ADDI)         st <= ADDIEX;
          else if (op == OP_J)            st <= JEX;
          else                            st <= FETCH;
        end
        MEMADR:  st <= is_sw ? MEMWR : MEMRD;
        MEMRD:   st <= MEMWB;
        RTYPEEX: st <= RTYPEWB;
        ADDIEX:  st <= ADDIWB;
        default: st <= FETCH;
      endcase
    end
  end

  logic ir_w, pc_w, br_w, rf_w, mem_w;

  always_comb begin
    ir_w     = 1'b0;
    pc_w     = 1'b0;
    br_w     = 1'b0;
    rf_w     = 1'b0;
    mem_w    = 1'b0;
    iord     = 1'b0;
    regDst   = 1'b0;
    memtoReg = 1'b0;
    aluSrcA  = 1'b0;
    aluSrcB  = 2'b00;
    aluOp    = 2'b00;
    pcSrc    = 2'b00;
    case (st)
      FETCH: begin
        ir_w    = 1'b1;
        pc_w    = 1'b1;
        aluSrcB = 2'b01;
      end
      DECODE: aluSrcB = 2'b11;
      MEMADR: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
      end
      MEMRD: iord = 1'b1;
      MEMWB: begin
        rf_w     = 1'b1;
        memtoReg = 1'b1;
      end
      MEMWR: begin
        iord  = 1'b1;
        mem_w = 1'b1;
      end
      RTYPEEX: begin
        aluSrcA = 1'b1;
        aluOp   = 2'b10;
      end
      RTYPEWB: begin
        rf_w   = 1'b1;
        regDst = 1'b1;
      end
      BEQEX: begin
        aluSrcA = 1'b1;
        aluOp   = 2'b01;
        pcSrc   = 2'b01;
        br_w    = 1'b1;
      end
      ADDIEX: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
      end
      ADDIWB: rf_w = 1'b1;
      JEX: begin
        pc_w  = 1'b1;
        pcSrc = 2'b10;
      end
      default: ;
    endcase
  end

  // Write enables are held off while reset is asserted; the mux
  // selects keep following the state.
  assign irWrite  = ir_w  & ~reset;
  assign pcWrite  = pc_w  & ~reset;
  assign branch   = br_w  & ~reset;
  assign regWrite = rf_w  & ~reset;
  assign memWrite = mem_w & ~reset;
  assign state    = st;

endmodule
